// File: rtl/bit_serializer.sv
// rtl/bit_serializer.sv - parallel-to-serial converter with a one-word holding register
// Feeds the bit-stream detectors one bit per clock over a valid/ready serial port.
module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_in_data,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  output logic             o_out_bit,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic             o_out_last
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_sh, w_sh_nxt;
  logic [WIDTH-1:0] r_hold, w_hold_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic             r_hold_full, w_hold_full_nxt;
  logic             w_in_xfer, w_out_xfer, w_final;
  logic [WIDTH-1:0] w_sh_shifted;

  assign o_in_ready  = !r_hold_full && !reset;
  assign o_out_valid = (r_state == SHIFT);
  assign o_out_bit   = MSB_FIRST ? r_sh[WIDTH-1] : r_sh[0];
  assign o_out_last  = o_out_valid && (r_cnt == LAST_CNT);

  assign w_in_xfer    = i_in_valid && o_in_ready;
  assign w_out_xfer   = o_out_valid && i_out_ready;
  assign w_final      = w_out_xfer && o_out_last;
  assign w_sh_shifted = MSB_FIRST ? {r_sh[WIDTH-2:0], 1'b0} : {1'b0, r_sh[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_sh        <= '0;
      r_hold      <= '0;
      r_cnt       <= '0;
      r_hold_full <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_sh        <= w_sh_nxt;
      r_hold      <= w_hold_nxt;
      r_cnt       <= w_cnt_nxt;
      r_hold_full <= w_hold_full_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_sh_nxt        = r_sh;
    w_hold_nxt      = r_hold;
    w_cnt_nxt       = r_cnt;
    w_hold_full_nxt = r_hold_full;
    case (r_state)
      IDLE: begin
        if (w_in_xfer) begin
          w_sh_nxt    = i_in_data;
          w_cnt_nxt   = '0;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (w_final) begin
          // Word boundary: the held word wins over a word arriving this cycle.
          w_cnt_nxt = '0;
          if (r_hold_full) begin
            w_sh_nxt        = r_hold;
            w_hold_full_nxt = 1'b0;
          end else if (w_in_xfer) begin
            w_sh_nxt = i_in_data;
          end else begin
            w_sh_nxt    = '0;
            w_state_nxt = IDLE;
          end
        end else begin
          if (w_out_xfer) begin
            w_sh_nxt  = w_sh_shifted;
            w_cnt_nxt = r_cnt + CW'(1);
          end
          if (w_in_xfer) begin
            w_hold_nxt      = i_in_data;
            w_hold_full_nxt = 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_bit_serializer.sv
// tb/tb_bit_serializer.sv - self-checking bench for bit_serializer (MSB-first and LSB-first instances)
// A queue of pending {last,bit} pairs per instance is the reference model.
module tb_bit_serializer;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] i_in_data;
  logic         i_in_valid;
  logic         i_out_ready;
  logic         o_in_ready, o_out_bit, o_out_valid, o_out_last;
  logic         l_in_ready, l_out_bit, l_out_valid, l_out_last;

  int errors = 0;
  int checks = 0;
  logic [1:0] q_m[$];
  logic [1:0] q_l[$];
  bit last_in_x, last_out_x;

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .reset(reset), .i_in_data(i_in_data), .i_in_valid(i_in_valid),
    .o_in_ready(o_in_ready), .o_out_bit(o_out_bit), .o_out_valid(o_out_valid),
    .i_out_ready(i_out_ready), .o_out_last(o_out_last)
  );

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .reset(reset), .i_in_data(i_in_data), .i_in_valid(i_in_valid),
    .o_in_ready(l_in_ready), .o_out_bit(l_out_bit), .o_out_valid(l_out_valid),
    .i_out_ready(i_out_ready), .o_out_last(l_out_last)
  );

  function automatic int nwords();
    int n = 0;
    foreach (q_m[i]) if (q_m[i][1]) n++;
    return n;
  endfunction

  function automatic bit exp_ready();
    return (nwords() < 2) && !reset;
  endfunction

  // One clock: update the model from the handshakes seen at the edge, then settle 1 time unit past it.
  task automatic tick();
    bit in_x, out_x;
    logic [W-1:0] w;
    in_x  = i_in_valid && exp_ready();
    out_x = i_out_ready && (q_m.size() > 0);
    w     = i_in_data;
    @(posedge clk);
    if (reset) begin
      q_m.delete();
      q_l.delete();
    end else begin
      if (out_x) begin
        void'(q_m.pop_front());
        void'(q_l.pop_front());
      end
      if (in_x) begin
        for (int i = 0; i < W; i++) begin
          q_m.push_back({i == W - 1, w[W-1-i]});
          q_l.push_back({i == W - 1, w[i]});
        end
      end
    end
    last_in_x  = in_x && !reset;
    last_out_x = out_x && !reset;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; i_in_valid = 1'b0; i_out_ready = 1'b1; i_in_data = '0;
    tick(); tick();
    checks++; if (o_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", o_out_valid); end
    checks++; if (o_in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", o_in_ready); end
    checks++; if (o_out_bit !== 1'b0) begin errors++; $display("FAIL reset_out_bit got=%b exp=0", o_out_bit); end
    checks++; if (o_out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got=%b exp=0", o_out_last); end
    reset = 1'b0;
    #1;
    checks++; if (o_in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got=%b exp=1", o_in_ready); end
    checks++; if (o_out_valid !== 1'b0) begin errors++; $display("FAIL release_out_valid got=%b exp=0", o_out_valid); end
  endtask

  task automatic test_single();
    logic [W-1:0] got, gotl;
    int nvalid, nvalid_l, nlast, lastc, firstc, det;
    got = '0; gotl = '0; nvalid = 0; nvalid_l = 0; nlast = 0; lastc = -1; firstc = -1; det = 0;
    i_in_data = 8'h96; i_in_valid = 1'b1; i_out_ready = 1'b1;
    tick();
    i_in_valid = 1'b0;
    for (int c = 0; c < 11; c++) begin
      if (o_out_valid) begin
        got = {got[W-2:0], o_out_bit};
        nvalid++;
        if (firstc < 0) firstc = c;
        if (o_out_last) begin nlast++; lastc = c; end
      end
      if (l_out_valid) begin
        gotl = {gotl[W-2:0], l_out_bit};
        nvalid_l++;
      end
      tick();
    end
    for (int i = 0; i <= W - 4; i++) if (got[W-1-i -: 4] == 4'b1001) det++;
    checks++; if (got !== 8'h96) begin errors++; $display("FAIL single_msb_bits got=%h exp=96", got); end
    checks++; if (gotl !== 8'h69) begin errors++; $display("FAIL single_lsb_bits got=%h exp=69", gotl); end
    checks++; if (nvalid != 8) begin errors++; $display("FAIL single_valid_cycles got=%0d exp=8", nvalid); end
    checks++; if (nvalid_l != 8) begin errors++; $display("FAIL single_lsb_valid_cycles got=%0d exp=8", nvalid_l); end
    checks++; if (firstc != 0) begin errors++; $display("FAIL single_latency got=%0d exp=0", firstc); end
    checks++; if (lastc != 7 || nlast != 1) begin errors++; $display("FAIL single_last got_pos=%0d got_n=%0d exp_pos=7 exp_n=1", lastc, nlast); end
    checks++; if (det != 1) begin errors++; $display("FAIL single_detect_1001 got=%0d exp=1", det); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] got16;
    int sent, nvalid, nlow, firstlow, run, maxrun;
    got16 = '0; sent = 0; nvalid = 0; nlow = 0; firstlow = -1; run = 0; maxrun = 0;
    i_in_data = 8'h96; i_in_valid = 1'b1; i_out_ready = 1'b1;
    for (int c = 0; c < 22; c++) begin
      tick();
      if (last_in_x) begin
        sent++;
        if (sent == 1) i_in_data = 8'h5A;
        else i_in_valid = 1'b0;
      end
      if (o_out_valid) begin
        got16 = {got16[14:0], o_out_bit};
        nvalid++; run++;
        if (run > maxrun) maxrun = run;
      end else run = 0;
      if (!o_in_ready) begin
        nlow++;
        if (firstlow < 0) firstlow = c;
      end
    end
    checks++; if (got16 !== 16'h965A) begin errors++; $display("FAIL b2b_bits got=%h exp=965a", got16); end
    checks++; if (nvalid != 16 || maxrun != 16) begin errors++; $display("FAIL b2b_contiguous got_valid=%0d got_run=%0d exp=16", nvalid, maxrun); end
    checks++; if (sent != 2) begin errors++; $display("FAIL b2b_accepted got=%0d exp=2", sent); end
    checks++; if (nlow != 7 || firstlow != 1) begin errors++; $display("FAIL b2b_in_ready_low got_n=%0d got_first=%0d exp_n=7 exp_first=1", nlow, firstlow); end
  endtask

  task automatic test_stall();
    logic [W-1:0] w1, w2, second;
    int vcnt, nv1, n1, n2, stall_bad, hold_acc;
    bit done1;
    w1 = '0; w2 = '0; vcnt = 0; nv1 = 0; n1 = 0; n2 = 0; stall_bad = 0; hold_acc = -1; done1 = 1'b0;
    second = W'($urandom);
    i_in_data = 8'hA5; i_in_valid = 1'b1; i_out_ready = 1'b1;
    tick();
    i_in_valid = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (o_out_valid) begin
        vcnt++;
        if (!done1) nv1++;
        i_out_ready = !(vcnt >= 3 && vcnt <= 5);
        if (vcnt >= 3 && vcnt <= 5 && o_out_bit !== 1'b1) stall_bad++;
        if (vcnt == 3) begin i_in_valid = 1'b1; i_in_data = second; end
        if (i_out_ready) begin
          if (!done1) begin
            w1 = {w1[W-2:0], o_out_bit}; n1++;
            if (o_out_last) done1 = 1'b1;
          end else if (n2 < W) begin
            w2 = {w2[W-2:0], o_out_bit}; n2++;
          end
        end
      end
      tick();
      if (last_in_x && i_in_valid) begin hold_acc = vcnt; i_in_valid = 1'b0; end
    end
    i_out_ready = 1'b1;
    checks++; if (w1 !== 8'hA5 || n1 != 8) begin errors++; $display("FAIL stall_bits got=%h n=%0d exp=a5 n=8", w1, n1); end
    checks++; if (nv1 != 11) begin errors++; $display("FAIL stall_valid_cycles got=%0d exp=11", nv1); end
    checks++; if (stall_bad != 0) begin errors++; $display("FAIL stall_bit_hold got_bad=%0d exp=0", stall_bad); end
    checks++; if (hold_acc < 3 || hold_acc > 5) begin errors++; $display("FAIL stall_hold_accept got=%0d exp=3..5", hold_acc); end
    checks++; if (w2 !== second || n2 != 8) begin errors++; $display("FAIL stall_second_word got=%h n=%0d exp=%h n=8", w2, n2, second); end
  endtask

  task automatic test_direct();
    logic [15:0] got16;
    int sent, nvalid, nlow, run, maxrun;
    got16 = '0; sent = 0; nvalid = 0; nlow = 0; run = 0; maxrun = 0;
    i_in_data = 8'h00; i_in_valid = 1'b1; i_out_ready = 1'b1;
    tick();
    i_in_valid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (o_out_valid) begin
        got16 = {got16[14:0], o_out_bit};
        nvalid++; run++;
        if (run > maxrun) maxrun = run;
      end else run = 0;
      if (!o_in_ready) nlow++;
      if (o_out_valid && o_out_last && sent == 0) begin i_in_valid = 1'b1; i_in_data = 8'hFF; end
      tick();
      if (last_in_x) begin sent++; i_in_valid = 1'b0; end
    end
    checks++; if (got16 !== 16'h00FF) begin errors++; $display("FAIL direct_bits got=%h exp=00ff", got16); end
    checks++; if (nvalid != 16 || maxrun != 16) begin errors++; $display("FAIL direct_contiguous got_valid=%0d got_run=%0d exp=16", nvalid, maxrun); end
    checks++; if (nlow != 0) begin errors++; $display("FAIL direct_hold_unused got_low_cycles=%0d exp=0", nlow); end
    checks++; if (sent != 1) begin errors++; $display("FAIL direct_accepted got=%0d exp=1", sent); end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] got;
    int nvalid, resid;
    got = '0; nvalid = 0; resid = 0;
    i_in_data = 8'h96; i_in_valid = 1'b1; i_out_ready = 1'b1;
    tick();
    i_in_data = 8'h5A;
    tick();
    i_in_valid = 1'b0;
    tick(); tick();
    reset = 1'b1;
    #1;
    checks++; if (o_in_ready !== 1'b0) begin errors++; $display("FAIL rstmid_in_ready_during got=%b exp=0", o_in_ready); end
    tick();
    checks++; if (o_out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid got=%b exp=0", o_out_valid); end
    checks++; if (o_out_bit !== 1'b0 || o_out_last !== 1'b0) begin errors++; $display("FAIL rstmid_bit_last got=%b%b exp=00", o_out_bit, o_out_last); end
    reset = 1'b0;
    #1;
    checks++; if (o_in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready_after got=%b exp=1", o_in_ready); end
    for (int c = 0; c < 5; c++) begin
      if (o_out_valid || l_out_valid) resid++;
      tick();
    end
    checks++; if (resid != 0) begin errors++; $display("FAIL rstmid_residual got=%0d exp=0", resid); end
    i_in_data = 8'h81; i_in_valid = 1'b1;
    tick();
    i_in_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (o_out_valid) begin got = {got[W-2:0], o_out_bit}; nvalid++; end
      tick();
    end
    checks++; if (got !== 8'h81 || nvalid != 8) begin errors++; $display("FAIL rstmid_new_word got=%h n=%0d exp=81 n=8", got, nvalid); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      reset       = ($urandom_range(0, 299) == 0);
      i_in_valid  = ($urandom_range(0, 3) != 0);
      i_in_data   = W'($urandom);
      i_out_ready = ($urandom_range(0, 4) != 0);
      #1;
      checks++; if (o_in_ready !== exp_ready()) begin errors++; $display("FAIL rand_in_ready cyc=%0d got=%b exp=%b", c, o_in_ready, exp_ready()); end
      checks++; if (l_in_ready !== exp_ready()) begin errors++; $display("FAIL rand_lsb_in_ready cyc=%0d got=%b exp=%b", c, l_in_ready, exp_ready()); end
      checks++; if (o_out_valid !== (q_m.size() > 0)) begin errors++; $display("FAIL rand_out_valid cyc=%0d got=%b exp=%b", c, o_out_valid, q_m.size() > 0); end
      checks++; if (l_out_valid !== (q_l.size() > 0)) begin errors++; $display("FAIL rand_lsb_out_valid cyc=%0d got=%b exp=%b", c, l_out_valid, q_l.size() > 0); end
      if (q_m.size() > 0) begin
        checks++; if ({o_out_last, o_out_bit} !== q_m[0]) begin errors++; $display("FAIL rand_msb_last_bit cyc=%0d got=%b%b exp=%b", c, o_out_last, o_out_bit, q_m[0]); end
      end
      if (q_l.size() > 0) begin
        checks++; if ({l_out_last, l_out_bit} !== q_l[0]) begin errors++; $display("FAIL rand_lsb_last_bit cyc=%0d got=%b%b exp=%b", c, l_out_last, l_out_bit, q_l[0]); end
      end
      tick();
    end
    reset = 1'b0; i_in_valid = 1'b0; i_out_ready = 1'b1;
  endtask

  initial begin
    last_in_x = 1'b0; last_out_x = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_direct();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/bit_serializer.md
# bit_serializer

Parallel-to-serial front end for the bit-stream sequence detectors (e.g. the 1001 detector). Accepts WIDTH-bit words over a valid/ready handshake and emits one bit per transferred cycle on a serial valid/ready port. It includes a one-word holding register so upstream can deliver the next word while the current one shifts out. Sustained throughput is one bit per clock with no bubbles between words.

## Interface
- WIDTH, default 8: word width in bits. Must be at least 2.
- MSB_FIRST, default 1: 1 sends bit WIDTH-1 first; 0 sends bit 0 first.

- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high.
- in_data  input  WIDTH  parallel word.
- in_valid  input  1  in_data valid.
- in_ready  output  1  block can accept a word; transfer when in_valid && in_ready at a clock edge.
- out_bit  output  1  current serial bit; drives the detector's inbit.
- out_valid  output  1  out_bit valid.
- out_ready  input  1  downstream consumes out_bit; transfer when out_valid && out_ready at a clock edge.
- out_last  output  1  high while out_bit is the final bit of a word.

## Operation
- Registers:
  - sh[WIDTH-1:0]: shift register.
  - cnt[$clog2(WIDTH)-1:0]: bits already sent from sh.
  - hold[WIDTH-1:0] and hold_full: holding register and its flag.
  - state in {IDLE, SHIFT}.
- in_ready = !hold_full && !reset.
- out_valid = (state == SHIFT).
- out_bit = MSB_FIRST ? sh[WIDTH-1] : sh[0].
- out_last = out_valid && (cnt == WIDTH-1).
- IDLE:
  - Input transfer loads in_data into sh, sets cnt = 0, state -> SHIFT.
  - hold_full is always 0 in IDLE.
- SHIFT, non-final bit transferred: sh shifts toward the output end (MSB_FIRST: left, else right), zero fill; cnt += 1.
- SHIFT, final bit transferred (out_last and out_ready): next word source, in priority order:
  1. hold_full = 1: sh <= hold, hold_full <= 0.
  2. Input transfer this same cycle: sh <= in_data, and hold is left untouched.
  3. Otherwise: state -> IDLE.
  - For cases 1 and 2, cnt <= 0 and state stays SHIFT.
- SHIFT, input transfer other than case 2 above: hold <= in_data, hold_full <= 1.
- Both registers full: in_ready = 0. Simultaneous acceptance into a full hold is therefore impossible.
- out_ready low: sh, cnt, out_bit and out_last hold their values. Input acceptance into an empty hold still proceeds.
- Bits are never dropped, duplicated or reordered. Words leave in arrival order.
- Reset (including mid-word):
  - Resulting state: state = IDLE, cnt = 0, sh = 0, hold = 0, hold_full = 0.
  - Any partial word and held word are discarded.
  - Outputs while reset is high and in the first cycle after: out_valid = 0, out_last = 0, out_bit = 0, in_ready = 0 while reset is high, then 1.

## Timing
- Latency: word accepted at edge N gives its first bit on out_bit during cycle N+1. All outputs are registered-state derived; only in_ready has a combinational term, from reset.
- With out_ready held at 1, each word occupies exactly WIDTH consecutive out_valid cycles.
- Back-to-back words produce no idle cycle if the next word is in hold, or is presented with in_valid, on or before the final-bit cycle.
- in_ready falls the cycle after a word enters hold. It rises the cycle after hold moves into sh.
- Maximum occupancy is 2 words: one in sh, one in hold.

## Test plan
- Single word 0x96, MSB_FIRST = 1, out_ready = 1:
  - out_bit = 1,0,0,1,0,1,1,0 on 8 consecutive cycles starting 1 cycle after acceptance.
  - out_last only on the 8th cycle, then out_valid = 0.
  - The downstream 1001 detector asserts detect once.
- Back-to-back 0x96 then 0x5A offered continuously:
  - 16 consecutive out_valid cycles, bits 10010110 01011010, no bubble.
  - in_ready = 0 from the cycle after 0x5A is accepted until 0x5A moves to sh.
- MSB_FIRST = 0, word 0x96: out_bit = 0,1,1,0,1,0,0,1.
- Stall, word 0xA5, out_ready low for serial cycles 3-5:
  - out_bit stays 1 (bit 5 of 0xA5), cnt frozen.
  - Total 11 out_valid cycles; serial sequence unchanged, 10100101.
  - A second word is accepted into hold during the stall.
- Direct load at word boundary: hold empty, next word 0xFF presented exactly on the final-bit cycle of 0x00.
  - Accepted straight into sh; 16 contiguous bits, eight 0s then eight 1s.
  - hold_full stays 0 throughout.
- Reset mid-word:
  - Reset asserted after 3 bits of 0x96 with 0x5A in hold: next cycle out_valid = 0, in_ready = 0.
  - After release: in_ready = 1, no residual bits emitted.
  - A new word 0x81 then serialises cleanly as 10000001.
